stream_fork_sched: RTL and testbench
====================================

STREAM_FORK_SCHED -- requirements
Module: stream_fork_sched

Interface
REQ-001 SHALL have parameter N_OUP, default 2, number of fork outputs (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, select-mask queue depth (>=2).
REQ-003 SHALL have parameter MAX_OUTST, default 4, per-output outstanding limit (>=1).
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_sel_i  input  N_OUP  requested output mask.
REQ-007 SHALL have port req_valid_i  input  1  mask request valid.
REQ-008 SHALL have port req_ready_o  output  1  mask request accepted.
REQ-009 SHALL have port sel_o  output  N_OUP  mask presented to the dynamic fork.
REQ-010 SHALL have port sel_valid_o  output  1  sel_o valid.
REQ-011 SHALL have port sel_ready_i  input  1  fork consumed sel_o.
REQ-012 SHALL have port done_i  input  N_OUP  per-output completion pulse, one outstanding retired per set bit.
REQ-013 SHALL have port drain_i  input  1  level drain request.
REQ-014 SHALL have port idle_o  output  1  drained: queue empty, all counters zero, state DRAINED.
REQ-015 SHALL have port err_o  output  1  sticky underflow error.

Function
REQ-016 SHALL buffer accepted masks in a DEPTH-entry FIFO; handshake req_valid_i&&req_ready_o pushes.
REQ-017 SHALL drive req_ready_o = !full && state==RUN; no push bypass when full, even with simultaneous pop.
REQ-018 SHALL discard an accepted all-zero mask (no push, no sel_o emission).
REQ-019 SHALL present the FIFO head on sel_o; earliest sel_valid_o is the cycle after the push (no fall-through).
REQ-020 SHALL keep one N_OUP-array of counters, width $clog2(MAX_OUTST+1).
REQ-021 SHALL assert sel_valid_o iff FIFO non-empty and cnt[i]<MAX_OUTST for every i with sel_o[i]=1, using registered counters only (no same-cycle credit forwarding from done_i).
REQ-022 SHALL keep sel_o stable and sel_valid_o asserted until sel_valid_o&&sel_ready_i.
REQ-023 SHALL, on sel handshake, pop the FIFO and increment cnt[i] for each set bit.
REQ-024 SHALL decrement cnt[i] on done_i[i]=1; simultaneous increment and decrement on the same i leaves cnt[i] unchanged.
REQ-025 SHALL ignore done_i[i] when cnt[i]==0 with no same-cycle increment, and set err_o, holding it until reset.
REQ-026 SHALL implement FSM states RUN, DRAIN, DRAINED.
REQ-027 SHALL transition RUN->DRAIN when drain_i=1; in DRAIN the FIFO keeps issuing, no new pushes accepted.
REQ-028 SHALL transition DRAIN->DRAINED when FIFO empty and all cnt==0; idle_o=1 only in DRAINED.
REQ-029 SHALL transition DRAINED->RUN when drain_i=0; DRAIN with drain_i=0 before empty returns to RUN.
REQ-030 SHALL, in DRAINED, still decrement on done_i (underflow then flagged per REQ-025).

Reset
REQ-031 SHALL, on rst_i=1 asynchronously: FIFO empty, pointers 0, all cnt=0, state RUN, err_o=0.
REQ-032 SHALL drive during reset: req_ready_o=0, sel_valid_o=0, sel_o=0, idle_o=0, err_o=0.
REQ-033 SHALL release reset synchronously to clk_i; req_ready_o may assert the first cycle after release.
REQ-034 SHALL discard queued masks and outstanding counts on reset mid-operation; no replay.

Structure
REQ-035 SHALL place the FSM state enum (RUN, DRAIN, DRAINED) in shared package stream_fork_sched_pkg.
REQ-036 SHALL implement the queue as sub-module fork_sel_fifo (parameters WIDTH, DEPTH; full/empty, push/pop).
REQ-037 SHALL keep counters and FSM in the top module; no other sub-modules.

Verification
REQ-038 SHALL cover: N_OUP=2, push 2'b11, sel_ready_i=1 -> sel_o=2'b11 valid one cycle later; cnt={1,1} after handshake.
REQ-039 SHALL cover: MAX_OUTST=4, five pushes of 2'b01, no done_i -> four handshakes, fifth sel_valid_o=0 until done_i=2'b01, then valid next cycle.
REQ-040 SHALL cover: DEPTH=4, sel_ready_i=0, push 4 masks -> req_ready_o=0; pop one while pushing -> push refused that cycle.
REQ-041 SHALL cover: cnt[0]=1, handshake with sel_o[0]=1 and done_i[0]=1 same cycle -> cnt[0] stays 1.
REQ-042 SHALL cover: done_i=2'b10 with cnt[1]=0 -> err_o=1, held; 2'b00 push -> no sel_valid_o.
REQ-043 SHALL cover: drain_i=1 with 2 queued, 3 outstanding -> req_ready_o=0, idle_o=1 after last done_i; drain_i=0 -> RUN; rst_i mid-drain -> all outputs at reset values.

Source files
------------

// File: rtl/stream_fork_sched_pkg.sv
// Shared types for the stream fork scheduler.
// Holds the drain FSM state encoding used by the top level.
package stream_fork_sched_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_e;

endpackage

// File: rtl/fork_sel_fifo.sv
// Select-mask queue: DEPTH-entry FIFO, head registered (no fall-through).
// Ports: clk_i/rst_i, push_i+data_i in, pop_i, data_o head, full_o, empty_o.
module fork_sel_fifo
  import stream_fork_sched_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push)
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (do_pop)
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; empty_o masks stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/stream_fork_sched.sv
// Schedules select masks to a dynamic fork with per-output credit limits.
// Ports: req_* mask in, sel_* mask out, done_i retire, drain_i/idle_o, err_o.
module stream_fork_sched
  import stream_fork_sched_pkg::*;
#(
  parameter int N_OUP     = 2,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_OUP-1:0] req_sel_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic [N_OUP-1:0] sel_o,
  output logic             sel_valid_o,
  input  logic             sel_ready_i,
  input  logic [N_OUP-1:0] done_i,
  input  logic             drain_i,
  output logic             idle_o,
  output logic             err_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q [N_OUP];
  logic [CW-1:0]   cnt_d [N_OUP];
  logic            err_q, err_d;
  logic [N_OUP-1:0] head;
  logic            full, empty;
  logic            push, hs;
  logic            credit_ok;
  logic            cnt_zero;

  // Zero masks are accepted but never queued.
  assign push = req_valid_i && req_ready_o && (|req_sel_i);
  assign hs   = sel_valid_o && sel_ready_i;

  fork_sel_fifo #(
    .WIDTH (N_OUP),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (req_sel_i),
    .pop_i   (hs),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Credit check uses registered counts only; done_i frees
  // credit one cycle later.
  always_comb begin
    credit_ok = 1'b1;
    cnt_zero  = 1'b1;
    for (int i = 0; i < N_OUP; i++) begin
      if (head[i] && (cnt_q[i] >= MAXC))
        credit_ok = 1'b0;
      if (cnt_q[i] != '0)
        cnt_zero = 1'b0;
    end
  end

  assign sel_valid_o = !empty && credit_ok;
  assign sel_o       = empty ? '0 : head;
  assign req_ready_o = !rst_i && !full && (state_q == RUN);
  assign idle_o      = (state_q == DRAINED);
  assign err_o       = err_q;

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < N_OUP; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs && head[i] && !done_i[i])
        cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!(hs && head[i]) && done_i[i]) begin
        if (cnt_q[i] == '0)
          err_d = 1'b1;
        else
          cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:
        if (drain_i) state_d = DRAIN;
      DRAIN:
        if (!drain_i)
          state_d = RUN;
        else if (empty && cnt_zero)
          state_d = DRAINED;
      DRAINED:
        if (!drain_i) state_d = RUN;
      default:
        state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      for (int i = 0; i < N_OUP; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int i = 0; i < N_OUP; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_stream_fork_sched.sv
// Self-checking bench for stream_fork_sched (N_OUP=2, DEPTH=4, MAX_OUTST=4).
// Scoreboard queue holds accepted masks; popped on each sel handshake.
module tb_stream_fork_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_sel = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready = 1'b0;
  logic [1:0] done = '0;
  logic       drain = 1'b0;
  logic       idle;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q [$];
  logic [1:0] e;

  always #5 clk = ~clk;

  stream_fork_sched #(
    .N_OUP     (2),
    .DEPTH     (4),
    .MAX_OUTST (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_sel_i   (req_sel),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .sel_o       (sel),
    .sel_valid_o (sel_valid),
    .sel_ready_i (sel_ready),
    .done_i      (done),
    .drain_i     (drain),
    .idle_o      (idle),
    .err_o       (err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    req_sel = '0; req_valid = 1'b0;
    sel_ready = 1'b0; done = '0; drain = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    clr_inputs();
    #1 rst = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", sel_valid); end
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL rst_sel: got %b want 00", sel); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", idle); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    req_sel = 2'b11; req_valid = 1'b1; sel_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", req_ready); end
    if (req_ready) exp_q.push_back(2'b11);
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL basic_nofall: got %b want 0", sel_valid); end
    cyc();
    req_valid = 1'b0;
    checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", sel_valid); end
    if (sel_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (sel !== e) begin errors++; $display("FAIL basic_sel: got %b want %b", sel, e); end
    end
    cyc();
    sel_ready = 1'b0;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b want 0", sel_valid); end
    done = 2'b11;
    cyc();
    done = 2'b00;
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_cnt: err got %b want 0", err); end
  endtask

  task automatic test_outstanding();
    int pushes = 0;
    int hs = 0;
    sel_ready = 1'b1; req_sel = 2'b01;
    for (int c = 0; c < 10; c++) begin
      req_valid = (pushes < 5);
      if (sel_valid && sel_ready) begin
        hs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL out_spurious: got sel %b want none", sel);
        end else begin
          e = exp_q.pop_front();
          if (sel !== e) begin errors++; $display("FAIL out_sel: got %b want %b", sel, e); end
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(2'b01);
        pushes++;
      end
      cyc();
    end
    req_valid = 1'b0;
    checks++; if (hs != 4) begin errors++; $display("FAIL out_hs: got %0d want 4", hs); end
    checks++; if (pushes != 5) begin errors++; $display("FAIL out_push: got %0d want 5", pushes); end
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL out_block: got %b want 0", sel_valid); end
    done = 2'b01;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL out_nofwd: got %b want 0", sel_valid); end
    cyc();
    done = 2'b00;
    checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL out_credit: got %b want 1", sel_valid); end
    if (sel_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (sel !== e) begin errors++; $display("FAIL out_last: got %b want %b", sel, e); end
    end
    cyc();
    sel_ready = 1'b0;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL out_empty: got %b want 0", sel_valid); end
    done = 2'b01;
    repeat (4) cyc();
    done = 2'b00;
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL out_err: got %b want 0", err); end
  endtask

  task automatic test_full();
    logic [1:0] m [4];
    m[0] = 2'b01; m[1] = 2'b10; m[2] = 2'b11; m[3] = 2'b01;
    sel_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_sel = m[i]; req_valid = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_acc%0d: got %b want 1", i, req_ready); end
      if (req_ready) exp_q.push_back(m[i]);
      cyc();
    end
    req_sel = 2'b10; req_valid = 1'b1; sel_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    if (req_ready) exp_q.push_back(2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sel_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL full_valid%0d: got %b want 1", i, sel_valid);
      end else begin
        e = exp_q.pop_front();
        if (sel !== e) begin errors++; $display("FAIL full_sel%0d: got %b want %b", i, sel, e); end
      end
      cyc();
      req_valid = 1'b0;
    end
    sel_ready = 1'b0;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL full_drop: got %b want 0", sel_valid); end
    done = 2'b11;
    cyc(); cyc();
    done = 2'b01;
    cyc();
    done = 2'b00;
    cyc();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err); end
  endtask

  task automatic test_simul();
    req_sel = 2'b01; req_valid = 1'b1; sel_ready = 1'b1;
    if (req_ready) exp_q.push_back(2'b01);
    cyc();
    req_valid = 1'b0;
    if (sel_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (sel !== e) begin errors++; $display("FAIL sim_sel0: got %b want %b", sel, e); end
    end
    cyc();
    req_valid = 1'b1;
    if (req_ready) exp_q.push_back(2'b01);
    cyc();
    req_valid = 1'b0;
    done = 2'b01;
    checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b want 1", sel_valid); end
    if (sel_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (sel !== e) begin errors++; $display("FAIL sim_sel1: got %b want %b", sel, e); end
    end
    cyc();
    done = 2'b00; sel_ready = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_keep: err got %b want 0", err); end
    done = 2'b01;
    cyc();
    done = 2'b00;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_one: err got %b want 0", err); end
    done = 2'b01;
    cyc();
    done = 2'b00;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sim_under: err got %b want 1", err); end
  endtask

  task automatic test_err();
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    done = 2'b10;
    cyc();
    done = 2'b00;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    repeat (3) cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b want 1", err); end
    req_sel = 2'b00; req_valid = 1'b1; sel_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", req_ready); end
    cyc();
    req_valid = 1'b0;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL zero_nosel: got %b want 0", sel_valid); end
    cyc();
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL zero_nosel2: got %b want 0", sel_valid); end
    sel_ready = 1'b0;
  endtask

  task automatic test_drain();
    logic [1:0] m [5];
    int k = 0;
    int hs = 0;
    int w = 0;
    m[0] = 2'b01; m[1] = 2'b10; m[2] = 2'b01; m[3] = 2'b11; m[4] = 2'b10;
    do_reset();
    sel_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = (k < 3);
      req_sel = (k < 3) ? m[k] : 2'b00;
      if (sel_valid && sel_ready && exp_q.size() > 0) begin
        hs++;
        e = exp_q.pop_front();
        checks++; if (sel !== e) begin errors++; $display("FAIL drn_sel: got %b want %b", sel, e); end
      end
      if (req_valid && req_ready) begin exp_q.push_back(m[k]); k++; end
      cyc();
    end
    sel_ready = 1'b0;
    checks++; if (hs != 3) begin errors++; $display("FAIL drn_hs: got %0d want 3", hs); end
    for (int i = 3; i < 5; i++) begin
      req_sel = m[i]; req_valid = 1'b1;
      if (req_ready) exp_q.push_back(m[i]);
      cyc();
    end
    req_valid = 1'b0;
    drain = 1'b1;
    cyc();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL drn_ready: got %b want 0", req_ready); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drn_idle0: got %b want 0", idle); end
    sel_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sel_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL drn_issue%0d: got %b want 1", i, sel_valid);
      end else begin
        e = exp_q.pop_front();
        if (sel !== e) begin errors++; $display("FAIL drn_q%0d: got %b want %b", i, sel, e); end
      end
      cyc();
    end
    sel_ready = 1'b0;
    done = 2'b11;
    cyc(); cyc();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drn_early: got %b want 0", idle); end
    cyc();
    done = 2'b00;
    while (!idle && w < 5) begin cyc(); w++; end
    checks++; if (idle !== 1'b1 || w != 1) begin errors++; $display("FAIL drn_idle: got %b after %0d want 1 after 1", idle, w); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drn_err: got %b want 0", err); end
    drain = 1'b0;
    cyc();
    checks++; if (idle !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL drn_resume: idle %b ready %b want 0 1", idle, req_ready); end
    req_sel = 2'b01; req_valid = 1'b1;
    cyc();
    req_sel = 2'b10;
    cyc();
    req_valid = 1'b0; drain = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++; if (req_ready !== 1'b0 || sel_valid !== 1'b0 || sel !== 2'b00 || idle !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst: rdy %b val %b sel %b idle %b err %b want 0 0 00 0 0", req_ready, sel_valid, sel, idle, err);
    end
    drain = 1'b0; sel_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++; if (sel_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL noreplay: val %b rdy %b want 0 1", sel_valid, req_ready); end
    sel_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_full();
    test_simul();
    test_err();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
